// File: rtl/rv32_alu_arith_logic_core.sv
// -----------------------------------------------------------------------------
// rv32_alu_arith_logic_core
//
// Registered RV32 execute-stage ALU: ADD/SUB with signed overflow flags,
// signed set-less-than, and bitwise AND/OR. Shift codes are handled by the
// neighbouring shift unit and produce zero here, as does the reserved code.
// Operands are sampled on the clock edge where in_valid is high. The result
// and its flags are visible one cycle later. When in_valid is low the
// registered result holds and out_valid drops.
//
// Parameters
//   WIDTH      datapath width in bits (two's-complement operands)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      a/b/alu_ctrl valid this cycle
//   a          in   WIDTH  operand A (signed)
//   b          in   WIDTH  operand B (signed)
//   alu_ctrl   in   3      000 SUB, 001 ADD, 010 AND, 011 OR, 110 SLT,
//                          100/101 shift codes, 111 reserved (both give y=0)
//   out_valid  out  1      y and flags hold a fresh result
//   y          out  WIDTH  registered result
//   zero       out  1      registered (y == 0)
//   pos_ovf    out  1      registered positive signed overflow (ADD/SUB)
//   neg_ovf    out  1      registered negative signed overflow (ADD/SUB)
// -----------------------------------------------------------------------------
module rv32_alu_arith_logic_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             pos_ovf,
  output logic             neg_ovf
);

  localparam logic [2:0] CTRL_SUB = 3'b000;
  localparam logic [2:0] CTRL_ADD = 3'b001;
  localparam logic [2:0] CTRL_AND = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b011;
  localparam logic [2:0] CTRL_SLT = 3'b110;

  // Overflow of the shared adder, given the sign of A, the sign of the
  // (possibly inverted) B actually fed to the adder, and the sign of the sum.
  // Because SUB feeds ~b, "a>=0, b<0, diff<0" becomes the same pattern as the
  // ADD positive-overflow case, so one rule covers both operations.
  // Returns {pos_ovf, neg_ovf}; both bits can never be set together.
  function automatic logic [1:0] addsub_ovf(input logic sign_a,
                                            input logic sign_b_eff,
                                            input logic sign_sum);
    logic pos;
    logic neg;
    pos = ~sign_a & ~sign_b_eff &  sign_sum;
    neg =  sign_a &  sign_b_eff & ~sign_sum;
    return {pos, neg};
  endfunction

  // True signed a < b. If the signs differ, the negative operand is smaller
  // and the wrapped difference must not be trusted (it may have overflowed).
  // With equal signs a-b cannot overflow, so the difference sign is exact.
  function automatic logic signed_lt(input logic sign_a,
                                     input logic sign_b,
                                     input logic sign_diff);
    logic lt;
    if (sign_a != sign_b) lt = sign_a;
    else                  lt = sign_diff;
    return lt;
  endfunction

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    sub_sel_p0;
  logic        [WIDTH-1:0] b_opnd_p0;
  logic        [WIDTH-1:0] sum_p0;
  logic        [1:0]       ovf_p0;
  logic                    lt_p0;
  logic        [WIDTH-1:0] res_p0;
  logic                    pos_p0;
  logic                    neg_p0;

  logic             vld_p1_d,  vld_p1_q;
  logic [WIDTH-1:0] y_p1_d,    y_p1_q;
  logic             zero_p1_d, zero_p1_q;
  logic             pos_p1_d,  pos_p1_q;
  logic             neg_p1_d,  neg_p1_q;

  assign a_s = a;
  assign b_s = b;

  // ---- stage p0: combinational datapath on the incoming operands ----------
  always_comb begin
    // SLT reuses the adder in subtract mode for the same-sign comparison.
    sub_sel_p0 = (alu_ctrl == CTRL_SUB) || (alu_ctrl == CTRL_SLT);
    b_opnd_p0  = sub_sel_p0 ? ~b : b;
    sum_p0     = a + b_opnd_p0 + {{(WIDTH-1){1'b0}}, sub_sel_p0};

    ovf_p0 = addsub_ovf(a_s[WIDTH-1], b_opnd_p0[WIDTH-1], sum_p0[WIDTH-1]);
    lt_p0  = signed_lt(a_s[WIDTH-1], b_s[WIDTH-1], sum_p0[WIDTH-1]);

    res_p0 = '0;
    pos_p0 = 1'b0;
    neg_p0 = 1'b0;
    unique case (alu_ctrl)
      CTRL_SUB, CTRL_ADD: begin
        res_p0 = sum_p0;
        pos_p0 = ovf_p0[1];
        neg_p0 = ovf_p0[0];
      end
      CTRL_AND: res_p0 = a & b;
      CTRL_OR:  res_p0 = a | b;
      CTRL_SLT: res_p0 = {{(WIDTH-1){1'b0}}, lt_p0};
      default:  res_p0 = '0;
    endcase
  end

  // ---- stage p0 -> p1: capture on accepted op, otherwise hold -------------
  always_comb begin
    vld_p1_d  = in_valid;
    y_p1_d    = y_p1_q;
    zero_p1_d = zero_p1_q;
    pos_p1_d  = pos_p1_q;
    neg_p1_d  = neg_p1_q;
    if (in_valid) begin
      y_p1_d    = res_p0;
      // Zero is taken from the final muxed result, so reserved codes and a
      // false SLT both report zero=1.
      zero_p1_d = (res_p0 == '0);
      pos_p1_d  = pos_p0;
      neg_p1_d  = neg_p0;
    end
  end

  // Result registers are cleared too, so outputs are never X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      y_p1_q    <= '0;
      zero_p1_q <= 1'b0;
      pos_p1_q  <= 1'b0;
      neg_p1_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      y_p1_q    <= y_p1_d;
      zero_p1_q <= zero_p1_d;
      pos_p1_q  <= pos_p1_d;
      neg_p1_q  <= neg_p1_d;
    end
  end

  // ---- stage p1: registered outputs ---------------------------------------
  assign out_valid = vld_p1_q;
  assign y         = y_p1_q;
  assign zero      = zero_p1_q;
  assign pos_ovf   = pos_p1_q;
  assign neg_ovf   = neg_p1_q;

endmodule

// File: tb/tb_rv32_alu_arith_logic_core.sv
module tb_rv32_alu_arith_logic_core;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_ctrl;
  logic        out_valid;
  logic [31:0] y;
  logic        zero;
  logic        pos_ovf;
  logic        neg_ovf;

  int ncmp  = 0;
  int nfail = 0;

  // Expected state of the registered outputs.
  logic        e_v;
  logic [31:0] e_y;
  logic        e_z;
  logic        e_po;
  logic        e_no;

  rv32_alu_arith_logic_core #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .y         (y),
    .zero      (zero),
    .pos_ovf   (pos_ovf),
    .neg_ovf   (neg_ovf)
  );

  always #5 clk = ~clk;

  // Reference: evaluate the operation on mathematical integers, then wrap.
  function automatic void model(input logic [2:0] c, input logic [31:0] av,
                                input logic [31:0] bv, output logic [31:0] ry,
                                output logic po, output logic no);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ry = 32'h0;
    po = 1'b0;
    no = 1'b0;
    case (c)
      3'd0, 3'd1: begin
        r  = (c == 3'd0) ? (sa - sb) : (sa + sb);
        po = (r > MAXV);
        no = (r < MINV);
        ry = r[31:0];
      end
      3'd2:    ry = av & bv;
      3'd3:    ry = av | bv;
      3'd6:    ry = (sa < sb) ? 32'd1 : 32'd0;
      default: ry = 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, e_v});
    chk({tag, ".y"},         y,                  e_y);
    chk({tag, ".zero"},      {31'b0, zero},      {31'b0, e_z});
    chk({tag, ".pos_ovf"},   {31'b0, pos_ovf},   {31'b0, e_po});
    chk({tag, ".neg_ovf"},   {31'b0, neg_ovf},   {31'b0, e_no});
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, check.
  task automatic cycle(input string tag, input logic v, input logic [2:0] c,
                       input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] ry;
    logic        po;
    logic        no;
    @(negedge clk);
    in_valid = v;
    alu_ctrl = c;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    if (rst) begin
      e_v = 1'b0; e_y = 32'h0; e_z = 1'b0; e_po = 1'b0; e_no = 1'b0;
    end else begin
      e_v = v;
      if (v) begin
        model(c, av, bv, ry, po, no);
        e_y = ry; e_z = (ry == 32'h0); e_po = po; e_no = no;
      end
    end
    check_all(tag);
  endtask

  // Directed op with hand-derived expected results checked on top of the model.
  task automatic dir(input string tag, input logic [2:0] c, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] ey, input logic ez,
                     input logic epo, input logic eno);
    cycle(tag, 1'b1, c, av, bv);
    chk({tag, ".y_const"},    y,                ey);
    chk({tag, ".zero_const"}, {31'b0, zero},    {31'b0, ez});
    chk({tag, ".pos_const"},  {31'b0, pos_ovf}, {31'b0, epo});
    chk({tag, ".neg_const"},  {31'b0, neg_ovf}, {31'b0, eno});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(7))
      0:       v = 32'h8000_0000;
      1:       v = 32'h7FFF_FFFF;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h0000_0000;
      4:       v = 32'($urandom_range(15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    e_v = 1'b0; e_y = 32'h0; e_z = 1'b0; e_po = 1'b0; e_no = 1'b0;
    rst = 1'b1; in_valid = 1'b1; alu_ctrl = 3'd1; a = 32'd1; b = 32'd2;

    // Reset held two cycles with in_valid asserted: reset must win.
    cycle("rst0", 1'b1, 3'd1, 32'h7FFF_FFFF, 32'd1);
    cycle("rst1", 1'b1, 3'd0, 32'd5, 32'd5);
    rst = 1'b0;
    cycle("hold_after_rst0", 1'b0, 3'd1, 32'd9, 32'd9);
    cycle("hold_after_rst1", 1'b0, 3'd3, 32'hFFFF_FFFF, 32'd0);

    dir("add_pos_ovf", 3'd1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dir("add_neg_ovf", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    dir("sub_equal",   3'd0, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0, 1'b0);
    dir("sub_neg_ovf", 3'd0, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    dir("sub_3_7",     3'd0, 32'd3,         32'd7,         32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    dir("sub_pos_ovf", 3'd0, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dir("slt_m1_1",    3'd6, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0, 1'b0, 1'b0);
    dir("slt_min_max", 3'd6, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    dir("slt_max_min", 3'd6, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    dir("slt_7_7",     3'd6, 32'd7,         32'd7,         32'h0000_0000, 1'b1, 1'b0, 1'b0);
    dir("and",         3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    dir("or",          3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    dir("add_set_ovf", 3'd1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dir("ctrl100",     3'd4, 32'h1234_5678, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    dir("ctrl101",     3'd5, 32'h1234_5678, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    dir("ctrl111",     3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // Back-to-back with gaps: results appear one cycle later and hold in gaps.
    dir("b2b_add",     3'd1, 32'd10,        32'd20,        32'd30,        1'b0, 1'b0, 1'b0);
    dir("b2b_sub",     3'd0, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    cycle("gap0", 1'b0, 3'd1, 32'd1, 32'd1);
    cycle("gap1", 1'b0, 3'd2, 32'd0, 32'd0);
    dir("b2b_or",      3'd3, 32'h0000_00FF, 32'h0000_FF00, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    cycle("gap2", 1'b0, 3'd0, 32'd1, 32'd1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(3) != 0), 3'($urandom_range(7)), pick(), pick());
    end

    // Reset in the middle of traffic discards the in-flight op.
    rst = 1'b1;
    cycle("mid_rst", 1'b1, 3'd1, 32'd1, 32'd1);
    rst = 1'b0;
    cycle("post_rst_hold", 1'b0, 3'd1, 32'd1, 32'd1);
    dir("post_rst_add", 3'd1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
